// File: rtl/ni_apb_responder_pkg.sv
// Shared NoC packet definitions and the responder's private types/helpers.

package pa_noc;
  localparam int COORD_W    = 4;
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef struct packed {
    logic                  valid;
    logic                  is_resp;
    logic                  write;
    logic [COORD_W-1:0]    dst_x;
    logic [COORD_W-1:0]    dst_y;
    logic [COORD_W-1:0]    src_x;
    logic [COORD_W-1:0]    src_y;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] data;
    logic                  slverr;
  } packet_t;

  localparam int APB_PACKET_WIDTH = $bits(packet_t);
endpackage

package ni_apb_responder_pkg;
  import pa_noc::*;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } resp_state_e;

  // Only the request fields needed to replay the transfer and route the answer.
  typedef struct packed {
    logic                  write;
    logic [COORD_W-1:0]    src_x;
    logic [COORD_W-1:0]    src_y;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] data;
  } req_t;

  // Assemble the response packet for a completed request.
  function automatic packet_t build_resp(input req_t req,
                                         input logic [COORD_W-1:0] my_x,
                                         input logic [COORD_W-1:0] my_y,
                                         input logic [APB_DATA_W-1:0] rdata,
                                         input logic err);
    packet_t p;
    p         = '0;
    p.valid   = 1'b1;
    p.is_resp = 1'b1;
    p.write   = req.write;
    p.dst_x   = req.src_x;
    p.dst_y   = req.src_y;
    p.src_x   = my_x;
    p.src_y   = my_y;
    p.addr    = req.addr;
    if (req.write) begin
      p.data = {APB_DATA_W{1'b0}};
    end else begin
      p.data = rdata;
    end
    p.slverr  = err;
    return p;
  endfunction
endpackage

// File: rtl/ni_apb_responder_if.sv
// APB requester/completer signal bundle with directional views.

interface ni_apb_responder_if
  import pa_noc::*;
;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [APB_ADDR_W-1:0] paddr;
  logic [APB_DATA_W-1:0] pwdata;
  logic                  pready;
  logic [APB_DATA_W-1:0] prdata;
  logic                  pslverr;

  modport master (output psel, penable, pwrite, paddr, pwdata,
                  input  pready, prdata, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                  output pready, prdata, pslverr);
endinterface

// File: rtl/ni_apb_responder_fifo.sv
// Synchronous FIFO; pointers carry an extra wrap bit to tell full from empty.

module ni_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             do_push_s, do_pop_s;

  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign o_rdata = mem_q[rd_ptr_q[AW-1:0]];

  // Qualify push/pop; a push into a full FIFO is legal only alongside a pop.
  always_comb begin
    do_pop_s  = i_pop && !o_empty;
    do_push_s = i_push && (!o_full || do_pop_s);
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge i_clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= i_wdata;
    end
  end
endmodule

// File: rtl/ni_apb_responder.sv
// Mesh-side APB responder: buffers requests, replays them on APB, returns responses.

module ni_apb_responder
  import pa_noc::*;
  import ni_apb_responder_pkg::*;
#(
  parameter int X_COORD    = 0,
  parameter int Y_COORD    = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_arst_n,
  input  logic [APB_PACKET_WIDTH-1:0] i_routerToNi,
  output logic [APB_PACKET_WIDTH-1:0] o_niToRouter,
  output logic                        o_psel,
  output logic                        o_penable,
  output logic                        o_pwrite,
  output logic [APB_ADDR_W-1:0]       o_paddr,
  output logic [APB_DATA_W-1:0]       o_pwdata,
  input  logic                        i_pready,
  input  logic [APB_DATA_W-1:0]       i_prdata,
  input  logic                        i_pslverr,
  output logic                        o_overflow,
  output logic                        o_misrouted
);
  localparam logic [COORD_W-1:0] MY_X = COORD_W'(X_COORD);
  localparam logic [COORD_W-1:0] MY_Y = COORD_W'(Y_COORD);
  localparam int REQ_W = $bits(req_t);

  packet_t          in_pkt_s;
  req_t             in_req_s, head_req_s, held_q, held_d;
  logic [REQ_W-1:0] fifo_rdata_s;
  logic             dst_hit_s, accept_s, push_s, pop_s, full_s, empty_s;
  logic             overflow_q, overflow_d, misrouted_q, misrouted_d;
  resp_state_e      state_q, state_d;
  logic             psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [APB_ADDR_W-1:0] paddr_q, paddr_d;
  logic [APB_DATA_W-1:0] pwdata_q, pwdata_d;
  packet_t          resp_pkt_q, resp_pkt_d;
  logic             unused_slverr_s;

  assign in_pkt_s        = packet_t'(i_routerToNi);
  assign head_req_s      = req_t'(fifo_rdata_s);
  assign unused_slverr_s = in_pkt_s.slverr;

  // Classify the incoming packet and update the sticky drop flags.
  always_comb begin
    dst_hit_s   = (in_pkt_s.dst_x == MY_X) && (in_pkt_s.dst_y == MY_Y);
    accept_s    = in_pkt_s.valid && !in_pkt_s.is_resp && dst_hit_s;
    pop_s       = (state_q == ST_IDLE) && !empty_s;
    push_s      = accept_s && (!full_s || pop_s);
    overflow_d  = overflow_q  | (accept_s && full_s && !pop_s);
    misrouted_d = misrouted_q | (in_pkt_s.valid && (in_pkt_s.is_resp || !dst_hit_s));
    in_req_s.write = in_pkt_s.write;
    in_req_s.src_x = in_pkt_s.src_x;
    in_req_s.src_y = in_pkt_s.src_y;
    in_req_s.addr  = in_pkt_s.addr;
    in_req_s.data  = in_pkt_s.data;
  end

  ni_fifo #(.WIDTH(REQ_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_push   (push_s),
    .i_wdata  (in_req_s),
    .i_pop    (pop_s),
    .o_rdata  (fifo_rdata_s),
    .o_full   (full_s),
    .o_empty  (empty_s)
  );

  // FSM state and held request registers.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= ST_IDLE;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
    end
  end

  // Next-state logic; the head of the FIFO is latched as it is popped.
  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s) begin
          state_d = ST_SETUP;
          held_d  = head_req_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (i_pready) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output values for the upcoming state so every output comes straight from a flop.
  always_comb begin
    psel_d    = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d = (state_d == ST_ACCESS);
    if (psel_d) begin
      pwrite_d = held_d.write;
      paddr_d  = held_d.addr;
      pwdata_d = held_d.data;
    end else begin
      pwrite_d = 1'b0;
      paddr_d  = {APB_ADDR_W{1'b0}};
      pwdata_d = {APB_DATA_W{1'b0}};
    end
    if (state_d == ST_RESP) begin
      resp_pkt_d = build_resp(held_q, MY_X, MY_Y, i_prdata, i_pslverr);
    end else begin
      resp_pkt_d = '0;
    end
  end

  // Registered APB, response and status outputs.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      resp_pkt_q  <= '0;
      overflow_q  <= 1'b0;
      misrouted_q <= 1'b0;
    end else begin
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      resp_pkt_q  <= resp_pkt_d;
      overflow_q  <= overflow_d;
      misrouted_q <= misrouted_d;
    end
  end

  assign o_psel       = psel_q;
  assign o_penable    = penable_q;
  assign o_pwrite     = pwrite_q;
  assign o_paddr      = paddr_q;
  assign o_pwdata     = pwdata_q;
  assign o_niToRouter = resp_pkt_q;
  assign o_overflow   = overflow_q;
  assign o_misrouted  = misrouted_q;
endmodule

// File: tb/tb_ni_apb_responder.sv
// Directed self-checking bench for ni_apb_responder at tile (1,2).

module tb_ni_apb_responder;
  import pa_noc::*;

  localparam int XC = 1;
  localparam int YC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [APB_PACKET_WIDTH-1:0] rtn;
  logic [APB_PACKET_WIDTH-1:0] ntr;
  logic ovf, mis;

  ni_apb_responder_if apb();

  int checks = 0;
  int failures = 0;
  int wait_cfg = 0;
  int wait_cnt = 0;
  int psel_cycles = 0;
  int base;
  logic [31:0] rdata_cfg = 32'h0;
  packet_t resp_q[$];

  always #5 clk = ~clk;

  ni_apb_responder #(.X_COORD(XC), .Y_COORD(YC), .FIFO_DEPTH(4)) dut (
    .i_clk        (clk),
    .i_arst_n     (rst_n),
    .i_routerToNi (rtn),
    .o_niToRouter (ntr),
    .o_psel       (apb.psel),
    .o_penable    (apb.penable),
    .o_pwrite     (apb.pwrite),
    .o_paddr      (apb.paddr),
    .o_pwdata     (apb.pwdata),
    .i_pready     (apb.pready),
    .i_prdata     (apb.prdata),
    .i_pslverr    (apb.pslverr),
    .o_overflow   (ovf),
    .o_misrouted  (mis)
  );

  // Completer model: wait_cfg wait states, error on address 0xBAD.
  assign apb.pready  = (wait_cnt >= wait_cfg);
  assign apb.prdata  = rdata_cfg;
  assign apb.pslverr = (apb.paddr == 32'h0000_0BAD);

  always @(posedge clk) begin
    if (apb.psel && apb.penable && !apb.pready) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  // Monitor: count APB select cycles and collect response packets.
  always @(negedge clk) begin
    if (apb.psel === 1'b1) psel_cycles <= psel_cycles + 1;
    if (ntr[APB_PACKET_WIDTH-1] === 1'b1) resp_q.push_back(packet_t'(ntr));
  end

  function automatic packet_t mk(input logic v, input logic r, input logic w,
                                 input logic [3:0] dx, input logic [3:0] dy,
                                 input logic [3:0] sx, input logic [3:0] sy,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input logic e);
    packet_t p;
    p.valid = v; p.is_resp = r; p.write = w;
    p.dst_x = dx; p.dst_y = dy; p.src_x = sx; p.src_y = sy;
    p.addr = a; p.data = d; p.slverr = e;
    return p;
  endfunction

  task automatic check(input string tag, input logic [APB_PACKET_WIDTH-1:0] obs,
                       input logic [APB_PACKET_WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input packet_t p);
    rtn = p;
    tick();
    rtn = '0;
  endtask

  initial begin
    rtn = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_apb", {apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata}, '0);
    check("rst_ntr", ntr, '0);
    check("rst_flags", {ovf, mis}, '0);
    rst_n = 1'b1;
    tick();

    // Zero-wait read from (0,0).
    wait_cfg = 0; rdata_cfg = 32'hDEAD_BEEF;
    send(mk(1'b1, 1'b0, 1'b0, 4'd1, 4'd2, 4'd0, 4'd0, 32'h10, 32'h0, 1'b0));
    check("rd_n1_idle", apb.psel, 1'b0);
    tick();
    check("rd_setup", {apb.psel, apb.penable, apb.pwrite, apb.paddr}, {1'b1, 1'b0, 1'b0, 32'h10});
    tick();
    check("rd_access", {apb.psel, apb.penable}, 2'b11);
    tick();
    check("rd_resp", ntr, mk(1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd1, 4'd2, 32'h10, 32'hDEAD_BEEF, 1'b0));
    tick();
    check("rd_resp_one_cycle", ntr, '0);

    // Write with three wait states.
    wait_cfg = 3;
    send(mk(1'b1, 1'b0, 1'b1, 4'd1, 4'd2, 4'd2, 4'd3, 32'h20, 32'h5A5A_5A5A, 1'b0));
    tick();
    check("wr_setup", {apb.psel, apb.penable, apb.pwrite, apb.pwdata}, {1'b1, 1'b0, 1'b1, 32'h5A5A_5A5A});
    for (int i = 0; i < 4; i++) begin
      tick();
      check("wr_access_hold", {apb.psel, apb.penable, apb.pwdata}, {1'b1, 1'b1, 32'h5A5A_5A5A});
    end
    tick();
    check("wr_resp", ntr, mk(1'b1, 1'b1, 1'b1, 4'd2, 4'd3, 4'd1, 4'd2, 32'h20, 32'h0, 1'b0));
    tick();

    // Misrouted packets: a response-type packet, then a wrong destination.
    wait_cfg = 0; resp_q.delete(); base = psel_cycles;
    check("mis_pre", mis, 1'b0);
    send(mk(1'b1, 1'b1, 1'b0, 4'd1, 4'd2, 4'd0, 4'd0, 32'h30, 32'h0, 1'b0));
    check("mis_isresp", mis, 1'b1);
    send(mk(1'b1, 1'b0, 1'b0, 4'd3, 4'd3, 4'd0, 4'd0, 32'h34, 32'h0, 1'b0));
    repeat (6) tick();
    check("mis_no_apb", psel_cycles - base, 32'd0);
    check("mis_no_resp", resp_q.size(), 32'd0);
    check("mis_no_ovf", ovf, 1'b0);

    // Slave error on a read, followed by a normal queued read.
    resp_q.delete(); rdata_cfg = 32'h1234_5678;
    send(mk(1'b1, 1'b0, 1'b0, 4'd1, 4'd2, 4'd0, 4'd1, 32'hBAD, 32'h0, 1'b0));
    send(mk(1'b1, 1'b0, 1'b0, 4'd1, 4'd2, 4'd0, 4'd1, 32'h44, 32'h0, 1'b0));
    repeat (14) tick();
    check("err_count", resp_q.size(), 32'd2);
    if (resp_q.size() >= 2) begin
      check("err_resp", resp_q[0], mk(1'b1, 1'b1, 1'b0, 4'd0, 4'd1, 4'd1, 4'd2, 32'hBAD, 32'h1234_5678, 1'b1));
      check("err_next", resp_q[1], mk(1'b1, 1'b1, 1'b0, 4'd0, 4'd1, 4'd1, 4'd2, 32'h44, 32'h1234_5678, 1'b0));
    end

    // Burst of six into a depth-4 buffer while the first transfer stalls.
    resp_q.delete(); wait_cfg = 2; rdata_cfg = 32'hC0DE_0000;
    for (int i = 0; i < 6; i++) begin
      send(mk(1'b1, 1'b0, 1'b0, 4'd1, 4'd2, 4'd0, i[3:0], 32'h100 + 32'(i), 32'h0, 1'b0));
    end
    check("burst_ovf", ovf, 1'b1);
    repeat (40) tick();
    check("burst_count", resp_q.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < resp_q.size()) check("burst_order", resp_q[i].addr, 32'h100 + 32'(i));
    end
    if (resp_q.size() >= 1) begin
      check("burst_first", resp_q[0], mk(1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd1, 4'd2, 32'h100, 32'hC0DE_0000, 1'b0));
    end

    // Asynchronous reset in the middle of ACCESS with a second request queued.
    resp_q.delete(); wait_cfg = 5;
    send(mk(1'b1, 1'b0, 1'b0, 4'd1, 4'd2, 4'd0, 4'd0, 32'h200, 32'h0, 1'b0));
    send(mk(1'b1, 1'b0, 1'b0, 4'd1, 4'd2, 4'd0, 4'd0, 32'h204, 32'h0, 1'b0));
    tick();
    check("arst_in_access", {apb.psel, apb.penable}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("arst_apb", {apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata}, '0);
    check("arst_ntr", ntr, '0);
    check("arst_flags", {ovf, mis}, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    base = psel_cycles;
    repeat (8) tick();
    check("arst_fifo_empty", psel_cycles - base, 32'd0);
    check("arst_no_resp", resp_q.size(), 32'd0);

    // Post-reset read with nominal latency.
    wait_cfg = 0; rdata_cfg = 32'hA5A5_0001;
    send(mk(1'b1, 1'b0, 1'b0, 4'd1, 4'd2, 4'd3, 4'd1, 32'h300, 32'h0, 1'b0));
    check("post_n1_idle", apb.psel, 1'b0);
    tick();
    check("post_setup", {apb.psel, apb.penable, apb.paddr}, {1'b1, 1'b0, 32'h300});
    tick();
    check("post_access", {apb.psel, apb.penable}, 2'b11);
    tick();
    check("post_resp", ntr, mk(1'b1, 1'b1, 1'b0, 4'd3, 4'd1, 4'd1, 4'd2, 32'h300, 32'hA5A5_0001, 1'b0));
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
